// File: rtl/wb_dma_copy.sv
// wb_dma_copy: Wishbone master copy engine.
// Moves len_i 32-bit words from src_adr_i to dst_adr_i, one classic
// single-beat read followed by one single-beat write per word, in
// ascending address order. A bus phase that sees no ack for TIMEOUT
// cycles is abandoned and the transfer ends with err_o set.
//
// Handshake: a bus phase holds cyc/stb (and adr/we/sel/dat) stable
// until ack is seen high at a rising edge; that edge completes the
// phase. ack may arrive combinationally in the same cycle as stb.
// ack outside a read or write phase is ignored.

module wb_dma_copy #(
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 64,
    parameter int TO_W    = 7
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             start_i,
    input  logic [31:0]      src_adr_i,
    input  logic [31:0]      dst_adr_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [LEN_W-1:0] words_done_o,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [3:0]       wbm_sel_o,
    output logic [31:0]      wbm_adr_o,
    output logic [31:0]      wbm_dat_o,
    input  logic             wbm_ack_i,
    input  logic [31:0]      wbm_dat_i
);

    // Last waiting cycle count before a phase is abandoned.
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WR   = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    // State register and its next value; r_state is the single place to
    // observe where the sequencer is.
    state_t r_state;
    state_t w_state_next;

    // Latched transfer parameters.
    logic [31:0]      r_src;
    logic [31:0]      r_dst;
    logic [LEN_W-1:0] r_len;

    // Word index; doubles as the count of fully written words.
    logic [LEN_W-1:0] r_idx;

    // Cycles spent waiting for ack in the current phase.
    logic [TO_W-1:0]  r_to;

    // Read data held between the read and write phase of a word.
    logic [31:0]      r_buf;

    // Sticky timeout flag.
    logic             r_err;

    // Decoded events.
    logic             w_start_acc;
    logic             w_in_phase;
    logic             w_ack;
    logic             w_to_expire;
    logic [LEN_W-1:0] w_idx_inc;
    logic             w_last;
    logic [31:0]      w_ofs;

    // Event decode: start only counts in IDLE, ack only counts in a phase.
    always_comb begin
        w_start_acc = (r_state == ST_IDLE) && start_i;
        w_in_phase  = (r_state == ST_RD) || (r_state == ST_WR);
        w_ack       = w_in_phase && wbm_ack_i;
        // ack on the same edge as the limit wins, so expiry needs !ack.
        w_to_expire = w_in_phase && !wbm_ack_i && (r_to == TO_LIMIT);
        w_idx_inc   = r_idx + LEN_W'(1);
        w_last      = (w_idx_inc == r_len);
        // Byte offset of the current word; 32-bit arithmetic wraps.
        w_ofs       = 32'(r_idx) << 2;
    end

    // State register with synchronous reset.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_state_next = (len_i == '0) ? ST_DONE : ST_RD;
                end
            end
            ST_RD: begin
                if (wbm_ack_i) begin
                    w_state_next = ST_WR;
                end else if (w_to_expire) begin
                    w_state_next = ST_ERR;
                end
            end
            ST_WR: begin
                if (wbm_ack_i) begin
                    w_state_next = w_last ? ST_DONE : ST_RD;
                end else if (w_to_expire) begin
                    w_state_next = ST_ERR;
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
            ST_ERR:  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Bus and status outputs decoded from registered state only, so no
    // combinational path exists from ack back onto the bus.
    always_comb begin
        wbm_cyc_o = 1'b0;
        wbm_stb_o = 1'b0;
        wbm_we_o  = 1'b0;
        wbm_sel_o = 4'h0;
        wbm_adr_o = 32'h0;
        wbm_dat_o = 32'h0;
        unique case (r_state)
            ST_RD: begin
                wbm_cyc_o = 1'b1;
                wbm_stb_o = 1'b1;
                wbm_sel_o = 4'hF;
                wbm_adr_o = r_src + w_ofs;
            end
            ST_WR: begin
                wbm_cyc_o = 1'b1;
                wbm_stb_o = 1'b1;
                wbm_we_o  = 1'b1;
                wbm_sel_o = 4'hF;
                wbm_adr_o = r_dst + w_ofs;
                wbm_dat_o = r_buf;
            end
            default: begin
                wbm_cyc_o = 1'b0;
            end
        endcase
        busy_o       = (r_state != ST_IDLE);
        done_o       = (r_state == ST_DONE) || (r_state == ST_ERR);
        err_o        = r_err;
        words_done_o = r_idx;
    end

    // Transfer parameters, word index, read buffer and error flag.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_src <= 32'h0;
            r_dst <= 32'h0;
            r_len <= '0;
            r_idx <= '0;
            r_buf <= 32'h0;
            r_err <= 1'b0;
        end else begin
            if (w_start_acc) begin
                r_src <= src_adr_i;
                r_dst <= dst_adr_i;
                r_len <= len_i;
                r_idx <= '0;
                r_err <= 1'b0;
            end
            if (w_ack && (r_state == ST_RD)) begin
                r_buf <= wbm_dat_i;
            end
            if (w_ack && (r_state == ST_WR)) begin
                r_idx <= w_idx_inc;
            end
            if (w_to_expire) begin
                r_err <= 1'b1;
            end
        end
    end

    // Timeout counter: restarts at every phase entry, counts ack-less cycles.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_to <= '0;
        end else if (w_start_acc || w_ack || !w_in_phase) begin
            r_to <= '0;
        end else begin
            r_to <= r_to + TO_W'(1);
        end
    end

endmodule

// File: doc/wb_dma_copy.md
Name: wb_dma_copy

Overview:
- Wishbone master copy engine: moves LEN 32-bit words from a source to a destination address range in user RAM.
- Issues one classic single-beat read, then one single-beat write, per word.
- Its master port feeds the DMA-side requester of the RAM arbiter, and it is the sequencer behind that port.
- Configured by a start strobe with source, destination and length; reports busy, done and timeout error.

Parameters:
- LEN_W, 16, width of word-count input and progress counter
- TIMEOUT, 64, cycles without ack before a bus phase is aborted (≥2)
- TO_W, 7, width of timeout counter; must hold TIMEOUT

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  reset
- start_i  in  1  start request, sampled in IDLE only
- src_adr_i  in  32  source byte address, word aligned
- dst_adr_i  in  32  destination byte address, word aligned
- len_i  in  LEN_W  number of words to copy
- busy_o  out  1  high in any state except IDLE
- done_o  out  1  one-cycle pulse at completion or abort
- err_o  out  1  timeout flag; sticky until the next accepted start
- words_done_o  out  LEN_W  words fully written so far
- wbm_cyc_o  out  1  Wishbone cycle
- wbm_stb_o  out  1  Wishbone strobe
- wbm_we_o  out  1  write enable
- wbm_sel_o  out  4  byte select
- wbm_adr_o  out  32  address
- wbm_dat_o  out  32  write data
- wbm_ack_i  in  1  acknowledge
- wbm_dat_i  in  32  read data

Behaviour:
- Clocking and reset: one clock, wb_clk_i. Reset wb_rst_i is synchronous and active-high.
- Reset values: state IDLE; all outputs 0, including cyc/stb/we/sel/adr/dat, words_done_o, err_o, done_o; internal counters and buffer 0.
- Reset mid-transfer: the bus drops at the next edge, with no completion pulse.
- States: IDLE, RD, WR, DONE, ERR.
- IDLE:
  - start_i=1 latches src, dst and len; clears err_o and words_done_o.
  - len_i≠0 → RD; len_i=0 → DONE.
  - start_i in any other state is ignored.
- RD:
  - Drives cyc=stb=1, we=0, sel=4'hF, adr=src+4·idx.
  - ack=1 at an edge: capture wbm_dat_i into the data buffer, → WR.
- WR:
  - Drives cyc=stb=1, we=1, sel=4'hF, adr=dst+4·idx, dat=buffer.
  - ack=1 at an edge: idx+1, words_done_o+1.
  - If new idx==len → DONE, else → RD.
- cyc/stb remain high across the RD→WR and WR→RD boundaries. They deassert only in DONE, ERR and IDLE.
- Bus signals are registered-state decodes only. ack is sampled at the clock edge; a same-cycle (combinational) ack is legal.
- Throughput: 2 cycles per word with zero-wait ack.
- Latency with zero-wait ack: start edge → done_o = 2·len+2 cycles.
- DONE: done_o=1 for exactly one cycle, → IDLE. busy_o is low the cycle after done_o.
- Timeout:
  - The timeout counter clears on each entry to RD or WR and increments each cycle without ack.
  - Reaching TIMEOUT with no ack → ERR.
  - ERR: bus deasserted, err_o=1, done_o pulses one cycle, → IDLE.
  - words_done_o holds the count reached.
- Ack arriving on the same edge the counter reaches TIMEOUT: the ack wins, and the phase completes normally.
- Address arithmetic is 32-bit modulo; crossing 32'hFFFF_FFFC wraps to 0.
- len_i at its max value (2^LEN_W−1) completes normally. idx is LEN_W bits wide and is compared by equality.
- Overlapping ranges are not detected; words copy in ascending order.
- wbm_ack_i while not in RD/WR is ignored.

Test Plan:
- Zero-wait copy:
  - Stimulus: start src=0x3800_0000, dst=0x3800_0100, len=4; ack the same cycle as stb.
  - Response: reads at 0x..000/004/008/00C interleaved with writes at 0x..100..10C; data copied.
  - done_o at cycle 10; words_done_o=4; err_o=0.
- Wait states:
  - Stimulus: ack delayed 3 cycles on every phase, len=2.
  - Response: cyc/stb held continuously with stable adr/we/dat during each wait; done_o after 4 phases × 4 cycles + 2.
- Timeout:
  - Stimulus: TIMEOUT=64, len=3; ack withheld on the second read.
  - Response: bus drops after 64 waiting cycles; err_o=1; done_o single pulse; words_done_o=1.
  - A new start clears err_o.
- len=0 and ignored start:
  - Stimulus: start with len=0, then start pulses while busy during a len=5 copy.
  - Response: len=0 gives done_o one cycle after start with no bus activity; mid-copy start pulses have no effect; len=5 completes.
- Address wrap:
  - Stimulus: src=0xFFFF_FFF8, len=3.
  - Response: read addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Reset mid-transfer:
  - Stimulus: assert wb_rst_i during a WR phase.
  - Response: next edge has cyc=stb=0, busy_o=0, words_done_o=0, done_o never pulses.
  - A subsequent start runs cleanly.
